// File: rtl/vgachargen_pkg.sv
// Shared constants, state/region encodings and glyph lane helpers for the
// vgachargen APB bridge.
package vgachargen_pkg;

  localparam int unsigned CH_MAP_BASE  = 0;
  localparam int unsigned COL_MAP_BASE = 1024;
  localparam int unsigned CH_T_BASE    = 2048;
  localparam int unsigned ID_ADDR      = 3072;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RMW_WR  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RESP    = 3'd4
  } bridge_state_e;

  typedef enum logic [2:0] {
    RG_NONE    = 3'd0,
    RG_CH_MAP  = 3'd1,
    RG_COL_MAP = 3'd2,
    RG_CH_T    = 3'd3,
    RG_ID      = 3'd4
  } region_e;

  // Replace one 32-bit lane of a 128-bit glyph; lane 0 is bits [31:0].
  function automatic logic [127:0] glyph_merge(input logic [127:0] glyph,
                                               input logic [1:0]   lane,
                                               input logic [31:0]  word);
    logic [127:0] r;
    r = glyph;
    for (int i = 0; i < 4; i++) begin
      if (lane == 2'(i)) r[32*i +: 32] = word;
    end
    return r;
  endfunction

  function automatic logic [31:0] glyph_lane(input logic [127:0] glyph,
                                             input logic [1:0]   lane);
    logic [31:0] r;
    r = glyph[31:0];
    for (int i = 1; i < 4; i++) begin
      if (lane == 2'(i)) r = glyph[32*i +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_vgachargen_bridge_if.sv
// APB3 bus bundle between the interconnect (master) and the bridge (slave).
interface apb_vgachargen_bridge_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output paddr, pwdata, pwrite, psel, penable,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, pwdata, pwrite, psel, penable,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_vgachargen_decode.sv
// Combinational word-index decoder: region, local map address, glyph index,
// lane and legality of the access.
module apb_vgachargen_decode
  import vgachargen_pkg::*;
#(
  parameter int unsigned IDX_W         = 12,
  parameter int unsigned CH_MAP_WORDS  = 600,
  parameter int unsigned COL_MAP_WORDS = 600,
  parameter int unsigned CH_T_GLYPHS   = 128,
  parameter int unsigned MAP_ADDR_W    = 10,
  parameter int unsigned CH_T_ADDR_W   = 7
) (
  input  logic [IDX_W-1:0]       idx,
  input  logic                   write,
  output region_e                region,
  output logic [MAP_ADDR_W-1:0]  map_addr,
  output logic [CH_T_ADDR_W-1:0] glyph,
  output logic [1:0]             lane,
  output logic                   legal
);

  localparam logic [31:0] CH_END  = 32'(CH_MAP_BASE + CH_MAP_WORDS);
  localparam logic [31:0] COL_LO  = 32'(COL_MAP_BASE);
  localparam logic [31:0] COL_END = 32'(COL_MAP_BASE + COL_MAP_WORDS);
  localparam logic [31:0] CHT_LO  = 32'(CH_T_BASE);
  localparam logic [31:0] CHT_END = 32'(CH_T_BASE + 4 * CH_T_GLYPHS);
  localparam logic [31:0] ID_IDX  = 32'(ID_ADDR);

  logic [31:0] idx_w;
  assign idx_w = 32'(idx);

  // Bounds are compared at 32 bits so a short index can never alias a region.
  always_comb begin
    region   = RG_NONE;
    map_addr = '0;
    glyph    = '0;
    lane     = idx[1:0];
    if (idx_w < CH_END) begin
      region   = RG_CH_MAP;
      map_addr = MAP_ADDR_W'(idx_w - 32'(CH_MAP_BASE));
    end else if (idx_w >= COL_LO && idx_w < COL_END) begin
      region   = RG_COL_MAP;
      map_addr = MAP_ADDR_W'(idx_w - COL_LO);
    end else if (idx_w >= CHT_LO && idx_w < CHT_END) begin
      region = RG_CH_T;
      glyph  = CH_T_ADDR_W'((idx_w - CHT_LO) >> 2);
    end else if (idx_w == ID_IDX) begin
      region = RG_ID;
    end
    legal = (region != RG_NONE) && !(region == RG_ID && write);
  end

endmodule

// File: rtl/apb_vgachargen_bridge.sv
// APB3 slave exposing the vgachargen char map, colour map, glyph table and
// ID register, with registered responses, glyph RMW and PSLVERR on bad access.
module apb_vgachargen_bridge
  import vgachargen_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 14,
  parameter int unsigned CH_MAP_WORDS   = 600,
  parameter int unsigned COL_MAP_WORDS  = 600,
  parameter int unsigned CH_T_GLYPHS    = 128,
  parameter int unsigned MAP_ADDR_W     = 10,
  parameter int unsigned CH_T_ADDR_W    = 7,
  parameter int unsigned MEM_RD_LATENCY = 1,
  parameter int unsigned WAIT_STATES    = 0,
  parameter logic [31:0] ID_VALUE       = 32'hFA11_1EAF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  apb_vgachargen_bridge_if.slave apb,
  output logic [MAP_ADDR_W-1:0]  ch_map_addr_o,
  output logic [31:0]            ch_map_data_o,
  output logic                   ch_map_wen_o,
  input  logic [31:0]            ch_map_data_i,
  output logic [MAP_ADDR_W-1:0]  col_map_addr_o,
  output logic [31:0]            col_map_data_o,
  output logic                   col_map_wen_o,
  input  logic [31:0]            col_map_data_i,
  output logic [CH_T_ADDR_W-1:0] ch_t_addr_o,
  output logic [127:0]           ch_t_data_o,
  output logic                   ch_t_wen_o,
  input  logic [127:0]           ch_t_data_i
);

  localparam int unsigned IDX_W   = APB_ADDR_WIDTH - 2;
  localparam int unsigned CNT_MAX = (MEM_RD_LATENCY > WAIT_STATES) ? MEM_RD_LATENCY : WAIT_STATES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_RD_WAIT = 3'(ST_RD_WAIT);
  localparam logic [2:0] S_RMW_WR  = 3'(ST_RMW_WR);
  localparam logic [2:0] S_HOLD    = 3'(ST_HOLD);
  localparam logic [2:0] S_RESP    = 3'(ST_RESP);

  region_e                dec_region;
  logic [MAP_ADDR_W-1:0]  dec_map_addr;
  logic [CH_T_ADDR_W-1:0] dec_glyph;
  logic [1:0]             dec_lane;
  logic                   dec_legal;
  logic                   unused_bits;

  assign unused_bits = ^apb.paddr[1:0];

  apb_vgachargen_decode #(
    .IDX_W        (IDX_W),
    .CH_MAP_WORDS (CH_MAP_WORDS),
    .COL_MAP_WORDS(COL_MAP_WORDS),
    .CH_T_GLYPHS  (CH_T_GLYPHS),
    .MAP_ADDR_W   (MAP_ADDR_W),
    .CH_T_ADDR_W  (CH_T_ADDR_W)
  ) u_decode (
    .idx     (apb.paddr[APB_ADDR_WIDTH-1:2]),
    .write   (apb.pwrite),
    .region  (dec_region),
    .map_addr(dec_map_addr),
    .glyph   (dec_glyph),
    .lane    (dec_lane),
    .legal   (dec_legal)
  );

  logic [2:0]             state_q,       state_nxt;
  logic [CNT_W-1:0]       cnt_q,         cnt_nxt;
  logic                   wr_q,          wr_nxt;
  logic                   err_q,         err_nxt;
  region_e                region_q,      region_nxt;
  logic [1:0]             lane_q,        lane_nxt;
  logic [31:0]            wdata_q,       wdata_nxt;
  logic [31:0]            prdata_q,      prdata_nxt;
  logic                   pready_q,      pready_nxt;
  logic                   pslverr_q,     pslverr_nxt;
  logic [MAP_ADDR_W-1:0]  ch_map_addr_q, ch_map_addr_nxt;
  logic [31:0]            ch_map_data_q, ch_map_data_nxt;
  logic                   ch_map_wen_q,  ch_map_wen_nxt;
  logic [MAP_ADDR_W-1:0]  col_addr_q,    col_addr_nxt;
  logic [31:0]            col_data_q,    col_data_nxt;
  logic                   col_wen_q,     col_wen_nxt;
  logic [CH_T_ADDR_W-1:0] ch_t_addr_q,   ch_t_addr_nxt;
  logic [127:0]           ch_t_data_q,   ch_t_data_nxt;
  logic                   ch_t_wen_q,    ch_t_wen_nxt;
  logic                   to_hold;
  logic [31:0]            rd_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      region_q      <= RG_NONE;
      lane_q        <= '0;
      wdata_q       <= '0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      ch_map_addr_q <= '0;
      ch_map_data_q <= '0;
      ch_map_wen_q  <= 1'b0;
      col_addr_q    <= '0;
      col_data_q    <= '0;
      col_wen_q     <= 1'b0;
      ch_t_addr_q   <= '0;
      ch_t_data_q   <= '0;
      ch_t_wen_q    <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      wr_q          <= wr_nxt;
      err_q         <= err_nxt;
      region_q      <= region_nxt;
      lane_q        <= lane_nxt;
      wdata_q       <= wdata_nxt;
      prdata_q      <= prdata_nxt;
      pready_q      <= pready_nxt;
      pslverr_q     <= pslverr_nxt;
      ch_map_addr_q <= ch_map_addr_nxt;
      ch_map_data_q <= ch_map_data_nxt;
      ch_map_wen_q  <= ch_map_wen_nxt;
      col_addr_q    <= col_addr_nxt;
      col_data_q    <= col_data_nxt;
      col_wen_q     <= col_wen_nxt;
      ch_t_addr_q   <= ch_t_addr_nxt;
      ch_t_data_q   <= ch_t_data_nxt;
      ch_t_wen_q    <= ch_t_wen_nxt;
    end
  end

  // Read data of the latched region, sampled at the end of RD_WAIT.
  always_comb begin
    case (region_q)
      RG_CH_MAP:  rd_sel = ch_map_data_i;
      RG_COL_MAP: rd_sel = col_map_data_i;
      RG_CH_T:    rd_sel = glyph_lane(ch_t_data_i, lane_q);
      default:    rd_sel = ID_VALUE;
    endcase
  end

  always_comb begin
    state_nxt       = state_q;
    cnt_nxt         = cnt_q;
    wr_nxt          = wr_q;
    err_nxt         = err_q;
    region_nxt      = region_q;
    lane_nxt        = lane_q;
    wdata_nxt       = wdata_q;
    prdata_nxt      = prdata_q;
    pready_nxt      = 1'b0;
    pslverr_nxt     = 1'b0;
    ch_map_addr_nxt = ch_map_addr_q;
    ch_map_data_nxt = ch_map_data_q;
    ch_map_wen_nxt  = 1'b0;
    col_addr_nxt    = col_addr_q;
    col_data_nxt    = col_data_q;
    col_wen_nxt     = 1'b0;
    ch_t_addr_nxt   = ch_t_addr_q;
    ch_t_data_nxt   = ch_t_data_q;
    ch_t_wen_nxt    = 1'b0;
    to_hold         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (apb.psel && apb.penable && !pready_q) begin
          wr_nxt     = apb.pwrite;
          region_nxt = dec_region;
          lane_nxt   = dec_lane;
          wdata_nxt  = apb.pwdata;
          err_nxt    = !dec_legal;
          cnt_nxt    = '0;
          if (!dec_legal) begin
            prdata_nxt = ID_VALUE;
            to_hold    = 1'b1;
          end else begin
            case (dec_region)
              RG_CH_MAP: begin
                ch_map_addr_nxt = dec_map_addr;
                if (apb.pwrite) begin
                  ch_map_data_nxt = apb.pwdata;
                  ch_map_wen_nxt  = 1'b1;
                  to_hold         = 1'b1;
                end else begin
                  state_nxt = S_RD_WAIT;
                end
              end
              RG_COL_MAP: begin
                col_addr_nxt = dec_map_addr;
                if (apb.pwrite) begin
                  col_data_nxt = apb.pwdata;
                  col_wen_nxt  = 1'b1;
                  to_hold      = 1'b1;
                end else begin
                  state_nxt = S_RD_WAIT;
                end
              end
              RG_CH_T: begin
                ch_t_addr_nxt = dec_glyph;
                state_nxt     = S_RD_WAIT;
              end
              default: begin
                prdata_nxt = ID_VALUE;
                to_hold    = 1'b1;
              end
            endcase
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CNT_W'(MEM_RD_LATENCY - 1)) begin
          if (region_q == RG_CH_T && wr_q) begin
            ch_t_data_nxt = glyph_merge(ch_t_data_i, lane_q, wdata_q);
            ch_t_wen_nxt  = 1'b1;
            state_nxt     = S_RMW_WR;
          end else begin
            prdata_nxt = rd_sel;
            to_hold    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_RMW_WR: to_hold = 1'b1;
      S_HOLD: begin
        if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
          state_nxt   = S_RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = err_q;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // With no wait states HOLD is skipped and the response is issued directly.
    if (to_hold) begin
      if (WAIT_STATES == 0) begin
        state_nxt   = S_RESP;
        pready_nxt  = 1'b1;
        pslverr_nxt = err_nxt;
      end else begin
        state_nxt = S_HOLD;
        cnt_nxt   = '0;
      end
    end
  end

  assign apb.prdata     = prdata_q;
  assign apb.pready     = pready_q;
  assign apb.pslverr    = pslverr_q;
  assign ch_map_addr_o  = ch_map_addr_q;
  assign ch_map_data_o  = ch_map_data_q;
  assign ch_map_wen_o   = ch_map_wen_q;
  assign col_map_addr_o = col_addr_q;
  assign col_map_data_o = col_data_q;
  assign col_map_wen_o  = col_wen_q;
  assign ch_t_addr_o    = ch_t_addr_q;
  assign ch_t_data_o    = ch_t_data_q;
  assign ch_t_wen_o     = ch_t_wen_q;

endmodule
